// File: rtl/lfsr_bank_sequencer.sv
// lfsr_bank_sequencer
//   Run controller for a bank of XNOR LFSRs. After start it collects one seed
//   per LFSR over a valid/ready handshake, replacing the XNOR lock-up pattern
//   (all ones) with a safe substitute. It then holds operation_start low for one
//   settle cycle so every LFSR loads its seed, steps through the warm-up words
//   with rng_valid low, and runs the bank for the programmed number of cycles.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   start           1-cycle request to begin a seed/run sequence (ignored while busy)
//   abort           stop the current sequence (ignored in IDLE)
//   run_cycles      run length in cycles, 0 = run until abort; sampled on start
//   seed_in         seed for LFSR slot seed_idx
//   seed_valid      seed_in valid
//   seed_ready      sequencer is accepting seeds
//   seed_idx        index of the next seed slot
//   seed_bus        all seeds; slice i = [i*SEED_W +: SEED_W] drives LFSR i
//   operation_start to all LFSRs; low = load seed, high = step
//   rng_valid       LFSR outputs are consumable random words this cycle
//   busy            sequencer is not idle
//   done            1-cycle pulse on normal completion
//   aborted         1-cycle pulse when abort terminates a sequence
//   seed_fixed      sticky flag: a lock-up seed was substituted; cleared on start
module lfsr_bank_sequencer #(
    parameter int                NUM_LFSR  = 8,
    parameter int                SEED_W    = 48,
    parameter int                CNT_W     = 32,
    parameter int                WARMUP    = 4,
    parameter logic [SEED_W-1:0] SAFE_SEED = 48'h5A5A_1234_C3C3,
    localparam int               IDX_W     = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           run_cycles,
    input  logic [SEED_W-1:0]          seed_in,
    input  logic                       seed_valid,
    output logic                       seed_ready,
    output logic [IDX_W-1:0]           seed_idx,
    output logic [NUM_LFSR*SEED_W-1:0] seed_bus,
    output logic                       operation_start,
    output logic                       rng_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic                       seed_fixed
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WARM   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int               WARM_W   = $clog2(WARMUP + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LFSR - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  run_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic [SEED_W-1:0] seeds [NUM_LFSR];

    // All ones is the XNOR lock-up state; substitute a slot-unique safe seed
    // so no two LFSRs end up running the same sequence.
    function automatic logic [SEED_W-1:0] fix_seed(input logic [SEED_W-1:0] s,
                                                    input logic [IDX_W-1:0]  i);
        if (&s)
            return SAFE_SEED ^ SEED_W'(i);
        else
            return s;
    endfunction

    for (genvar g = 0; g < NUM_LFSR; g++) begin : g_bus
        assign seed_bus[g*SEED_W +: SEED_W] = seeds[g];
    end

    assign seed_ready = (state == S_LOAD);
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (seed_valid && seed_idx == LAST_IDX) state_nx = S_SETTLE;
            S_SETTLE: state_nx = (WARMUP == 0) ? S_RUN : S_WARM;
            S_WARM:   if (warm_cnt == WARM_W'(1)) state_nx = S_RUN;
            S_RUN:    if (run_len != '0 && run_cnt == CNT_W'(1)) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // Abort overrides both a seed handshake and run-counter expiry.
        if (abort && state != S_IDLE)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            run_len         <= '0;
            run_cnt         <= '0;
            warm_cnt        <= '0;
            seed_idx        <= '0;
            seed_fixed      <= 1'b0;
            operation_start <= 1'b0;
            rng_valid       <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            for (int i = 0; i < NUM_LFSR; i++)
                seeds[i] <= '0;
        end else begin
            state <= state_nx;
            // Outputs are decoded from the next state so they line up with
            // the state register and have no combinational input path.
            operation_start <= (state_nx == S_WARM) || (state_nx == S_RUN);
            rng_valid       <= (state_nx == S_RUN);
            done            <= (state_nx == S_DONE);
            aborted         <= abort && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        run_len    <= run_cycles;
                        seed_idx   <= '0;
                        seed_fixed <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (seed_valid && !abort) begin
                        seeds[seed_idx] <= fix_seed(seed_in, seed_idx);
                        seed_idx        <= (seed_idx == LAST_IDX) ? '0 : seed_idx + 1'b1;
                        if (&seed_in)
                            seed_fixed <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    warm_cnt <= WARM_W'(WARMUP);
                    run_cnt  <= run_len;
                end
                S_WARM: begin
                    warm_cnt <= warm_cnt - 1'b1;
                end
                S_RUN: begin
                    if (run_len != '0)
                        run_cnt <= run_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_bank_sequencer.sv
// tb_lfsr_bank_sequencer
//   Directed bench for lfsr_bank_sequencer with NUM_LFSR=4, WARMUP=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_lfsr_bank_sequencer;

    localparam int N  = 4;
    localparam int SW = 48;
    localparam int CW = 32;
    localparam logic [SW-1:0] SAFE = 48'h5A5A_1234_C3C3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CW-1:0]   run_cycles = '0;
    logic [SW-1:0]   seed_in = '0;
    logic            seed_valid = 1'b0;
    logic            seed_ready;
    logic [1:0]      seed_idx;
    logic [N*SW-1:0] seed_bus;
    logic            operation_start;
    logic            rng_valid;
    logic            busy;
    logic            done;
    logic            aborted;
    logic            seed_fixed;

    int n_assert = 0;
    int n_fail   = 0;

    lfsr_bank_sequencer #(
        .NUM_LFSR (N),
        .SEED_W   (SW),
        .CNT_W    (CW),
        .WARMUP   (4),
        .SAFE_SEED(SAFE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .run_cycles     (run_cycles),
        .seed_in        (seed_in),
        .seed_valid     (seed_valid),
        .seed_ready     (seed_ready),
        .seed_idx       (seed_idx),
        .seed_bus       (seed_bus),
        .operation_start(operation_start),
        .rng_valid      (rng_valid),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .seed_fixed     (seed_fixed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] rc);
        start      = 1'b1;
        run_cycles = rc;
        step();
        start = 1'b0;
    endtask

    // Back-to-back seeds; returns at the first SETTLE sample.
    task automatic load4(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input logic [SW-1:0] s2, input logic [SW-1:0] s3);
        seed_valid = 1'b1;
        seed_in = s0; step();
        seed_in = s1; step();
        seed_in = s2; step();
        seed_in = s3; step();
        seed_valid = 1'b0;
        seed_in    = '0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (done) seen = 1;
            else step();
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        logic       v_pat [7];
        logic [47:0] d_pat [7];
        logic [1:0] idx_exp;
        bit         any_done;

        // ---------------- reset state ----------------
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(seed_ready), 64'd0);
        chk("rst_opstart", 64'(operation_start), 64'd0);
        chk("rst_rngvalid", 64'(rng_valid), 64'd0);
        chk("rst_done_abort_fixed", {61'd0, done, aborted, seed_fixed}, 64'd0);
        chk("rst_idx", 64'(seed_idx), 64'd0);
        chk("rst_bus_lo", seed_bus[127:64], 64'd0);
        rst = 1'b1;
        step();

        // abort in IDLE is ignored
        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_pulse", 64'(aborted), 64'd0);

        // ---------------- test 1: nominal run ----------------
        do_start(32'd10);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready", 64'(seed_ready), 64'd1);
        load4(48'd1, 48'd2, 48'd3, 48'd4);
        chk("t1_ready_drop", 64'(seed_ready), 64'd0);
        chk("t1_idx_wrap", 64'(seed_idx), 64'd0);
        // k=0 SETTLE, 1..4 WARMUP, 5..14 RUN, 15 DONE, 16 IDLE
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("t1_op_k%0d", k), 64'(operation_start), 64'(k >= 1 && k <= 14));
            chk($sformatf("t1_rv_k%0d", k), 64'(rng_valid), 64'(k >= 5 && k <= 14));
            chk($sformatf("t1_done_k%0d", k), 64'(done), 64'(k == 15));
            step();
        end
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_slice0", 64'(seed_bus[0*SW +: SW]), 64'd1);
        chk("t1_slice3", 64'(seed_bus[3*SW +: SW]), 64'd4);

        // ---------------- test 2: gapped seeds, start+abort in IDLE ----------------
        v_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        d_pat = '{48'h1111_0000_0001, 48'hDEAD_0000_0001, 48'h2222_0000_0002,
                  48'hDEAD_0000_0002, 48'hDEAD_0000_0003, 48'h3333_0000_0003,
                  48'h4444_0000_0004};
        start = 1'b1; abort = 1'b1; run_cycles = 32'd5;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t2_start_wins", 64'(busy), 64'd1);
        chk("t2_no_abort", 64'(aborted), 64'd0);
        idx_exp = 2'd0;
        for (int i = 0; i < 7; i++) begin
            seed_valid = v_pat[i];
            seed_in    = d_pat[i];
            step();
            if (v_pat[i]) idx_exp = idx_exp + 2'd1;
            chk($sformatf("t2_idx_%0d", i), 64'(seed_idx), 64'(idx_exp));
        end
        seed_valid = 1'b0;
        chk("t2_ready_drop", 64'(seed_ready), 64'd0);
        chk("t2_slice0", 64'(seed_bus[0*SW +: SW]), 64'h1111_0000_0001);
        chk("t2_slice1", 64'(seed_bus[1*SW +: SW]), 64'h2222_0000_0002);
        chk("t2_slice2", 64'(seed_bus[2*SW +: SW]), 64'h3333_0000_0003);
        chk("t2_slice3", 64'(seed_bus[3*SW +: SW]), 64'h4444_0000_0004);
        chk("t2_no_fix", 64'(seed_fixed), 64'd0);
        // test 4b: abort during WARMUP
        step();
        chk("t4b_in_warm", {62'd0, operation_start, rng_valid}, 64'd2);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4b_aborted", 64'(aborted), 64'd1);
        chk("t4b_op_low", 64'(operation_start), 64'd0);
        chk("t4b_idle", 64'(busy), 64'd0);
        chk("t4b_bus_kept", 64'(seed_bus[2*SW +: SW]), 64'h3333_0000_0003);
        step();
        chk("t4b_pulse_1cyc", 64'(aborted), 64'd0);
        chk("t4b_no_done", 64'(done), 64'd0);

        // ---------------- test 3: lock-up seed substitution ----------------
        do_start(32'd2);
        load4(48'd0, 48'd5, 48'hFFFF_FFFF_FFFF, 48'd7);
        chk("t3_fixed", 64'(seed_fixed), 64'd1);
        chk("t3_slice0_zero", 64'(seed_bus[0*SW +: SW]), 64'd0);
        chk("t3_slice2_safe", 64'(seed_bus[2*SW +: SW]), 64'h5A5A_1234_C3C1);
        chk("t3_slice3", 64'(seed_bus[3*SW +: SW]), 64'd7);
        wait_done(40, "t3_done_seen");
        chk("t3_fixed_sticky", 64'(seed_fixed), 64'd1);
        step();

        // ---------------- test 4a: abort during LOAD at idx 1 ----------------
        do_start(32'd3);
        chk("t3_fixed_cleared", 64'(seed_fixed), 64'd0);
        seed_valid = 1'b1; seed_in = 48'h0000_0000_0ABC; step();
        chk("t4a_idx1", 64'(seed_idx), 64'd1);
        seed_in = 48'h0000_0000_0DEF; abort = 1'b1; step();
        abort = 1'b0; seed_valid = 1'b0;
        chk("t4a_aborted", 64'(aborted), 64'd1);
        chk("t4a_ready_low", 64'(seed_ready), 64'd0);
        chk("t4a_slice0", 64'(seed_bus[0*SW +: SW]), 64'h0ABC);
        chk("t4a_slice1_kept", 64'(seed_bus[1*SW +: SW]), 64'd5);
        step();

        // ---------------- test 4c: abort on the last RUN cycle ----------------
        do_start(32'd3);
        load4(48'd11, 48'd12, 48'd13, 48'd14);
        for (int k = 0; k < 7; k++) step();
        chk("t4c_last_run", 64'(rng_valid), 64'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4c_aborted", 64'(aborted), 64'd1);
        chk("t4c_no_done", 64'(done), 64'd0);
        chk("t4c_op_low", {62'd0, operation_start, rng_valid}, 64'd0);
        step();
        chk("t4c_still_no_done", 64'(done), 64'd0);

        // ---------------- test 5: run_cycles=0, run until abort ----------------
        do_start(32'd0);
        load4(48'd21, 48'd22, 48'd23, 48'd24);
        any_done = 0;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (done) any_done = 1;
            if (k == 500) start = 1'b1;
            if (k == 501) start = 1'b0;
        end
        chk("t5_still_run", 64'(rng_valid), 64'd1);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_no_reload", 64'(seed_ready), 64'd0);
        chk("t5_never_done", 64'(any_done), 64'd0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t5_aborted", 64'(aborted), 64'd1);
        step();

        // ---------------- test 6: async reset during RUN ----------------
        do_start(32'd0);
        load4(48'd31, 48'd32, 48'd33, 48'd34);
        for (int k = 0; k < 5; k++) step();
        chk("t6_in_run", 64'(rng_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_outs", {59'd0, operation_start, rng_valid, done, aborted, seed_ready}, 64'd0);
        chk("t6_async_bus", 64'(seed_bus[0*SW +: SW]), 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("t6_no_pulse", {62'd0, done, aborted}, 64'd0);
        do_start(32'd2);
        load4(48'd41, 48'd42, 48'd43, 48'd44);
        wait_done(40, "t6_fresh_done");
        chk("t6_fresh_slice3", 64'(seed_bus[3*SW +: SW]), 64'd44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
